dcache_data_ctrl: RTL and testbench
===================================

DCACHE_DATA_CTRL -- requirements
Module: dcache_data_ctrl

Interface
REQ-001 Parameter INDEX_W, default 6, SRAM line index width; 64 lines.
REQ-002 Parameter LINE_W, default 128, line width in bits; 16 byte lanes.
REQ-003 clk  in  1  sole clock; also drives the SRAM clk0 pin.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 fill_valid/fill_ready  in/out  1/1  line-fill handshake.
REQ-006 fill_index  in  6  line to write; fill_data  in  128  full line.
REQ-007 st_valid/st_ready  in/out  1/1  store handshake.
REQ-008 st_index  in  6; st_offset  in  4  byte offset in line; st_size  in  2  (0=B,1=H,2=W,3=D); st_data  in  64  right-aligned data.
REQ-009 ld_valid/ld_ready  in/out  1/1  load handshake; ld_index  in  6; ld_offset  in  4; ld_size  in  2; ld_signed  in  1.
REQ-010 ld_rsp_valid/ld_rsp_ready  out/in  1/1  load response handshake; ld_rsp_data  out  64  extended result; ld_rsp_err  out  1  misaligned.
REQ-011 sram_csb, sram_web  out  1  active-low chip select / write enable; sram_wmask  out  16; sram_addr  out  6; sram_din  out  128; sram_dout  in  128.

Function
REQ-012 Handshake fires when valid and ready are both high at a rising clk edge; the SRAM samples the same-cycle sram_* outputs at that edge.
REQ-013 At most one request is issued per cycle; priority fill > store > load; a losing request sees ready low that cycle.
REQ-014 Fill: csb=0, web=0, wmask=16'hFFFF, addr=fill_index, din=fill_data.
REQ-015 Store: csb=0, web=0, addr=st_index, wmask=((1<<(1<<st_size))-1)<<st_offset, din=st_data replicated so lane st_offset carries st_data[7:0].
REQ-016 Load issue: csb=0, web=1, addr=ld_index, wmask=0.
REQ-017 Idle cycle: csb=1, web=1, wmask=0; addr/din 0.
REQ-018 Misalignment: st_offset or ld_offset not a multiple of (1<<size); misaligned store is accepted and dropped (csb=1); misaligned load is accepted without SRAM access and returns err=1, data=0, two cycles later.
REQ-019 Load FSM states IDLE, RD_WAIT, RSP.
REQ-020 IDLE: ld_ready=1 when no fill/store wins; load fire -> RD_WAIT.
REQ-021 RD_WAIT (exactly 1 cycle): no load accepted; fill/store accepted; at the end edge capture sram_dout (valid after the SRAM negedge), select bytes at offset, sign- or zero-extend per ld_signed to 64 bits into rsp register -> RSP.
REQ-022 RSP: ld_rsp_valid=1, data/err held stable until ld_rsp_ready; on fire -> IDLE; ld_ready=0 in RSP (no back-to-back overlap).
REQ-023 Load latency: fire at edge N, ld_rsp_valid high in the cycle after edge N+2... precisely: valid during cycle following edge N+2's predecessor, i.e. rsp visible two edges after issue; minimum issue interval 3 cycles.
REQ-024 A store to the same index accepted in RD_WAIT does not affect the in-flight load's data (SRAM read precedes write).
REQ-025 fill_ready and st_ready are high in every state except under reset or priority loss.
REQ-026 Load data for size D at offset 8 uses bytes 15:8; size D at offset 0 uses 7:0.

Reset
REQ-027 While rst=1: FSM=IDLE, ld_rsp_valid=0, ld_rsp_data=0, ld_rsp_err=0, all ready=0, sram_csb=1, sram_web=1, wmask=0, addr=0, din=0.
REQ-028 rst assertion in RD_WAIT or RSP discards the in-flight load; no response after release.
REQ-029 First request is accepted at the first rising edge after rst deasserts.

Verification
REQ-030 Fill index 5 with 128'h0F..00 pattern, load idx5 off 4 size W unsigned -> rsp 0x0000_0000_0706_0504 two edges after load fire.
REQ-031 Store idx5 off 3 size B data 0xFF, load off 0 size W signed -> wmask 16'h0008; rsp 0xFFFF_FFFF_FF02_0100.
REQ-032 Fill, store, load valid same cycle -> fill fires, store next, load third; ld_ready low first two cycles.
REQ-033 Load off 2 size W -> err=1, data=0, sram_csb stays 1 throughout.
REQ-034 ld_rsp_ready held low 5 cycles -> rsp data stable, ld_ready=0, concurrent store idx7 still accepted.
REQ-035 rst pulse during RD_WAIT -> no ld_rsp_valid afterwards, sram_csb=1 immediately.

Source files
------------

// File: rtl/dcache_data_ctrl.sv
// Data-array controller for a direct-mapped D-cache line SRAM: arbitrates line fills,
// byte-masked stores and loads onto a single-port SRAM and returns extended load data.
//
// state   | meaning
// IDLE    | no load in flight; a load may be accepted
// RD_WAIT | SRAM read issued, sram_dout captured at the end of this cycle
// RSP     | load response held on ld_rsp_* until ld_rsp_ready
module dcache_data_ctrl #(
    parameter int INDEX_W = 6,
    parameter int LINE_W  = 128
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fill_valid,
    output logic                       fill_ready,
    input  logic [INDEX_W-1:0]         fill_index,
    input  logic [LINE_W-1:0]          fill_data,
    input  logic                       st_valid,
    output logic                       st_ready,
    input  logic [INDEX_W-1:0]         st_index,
    input  logic [$clog2(LINE_W/8)-1:0] st_offset,
    input  logic [1:0]                 st_size,
    input  logic [63:0]                st_data,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [INDEX_W-1:0]         ld_index,
    input  logic [$clog2(LINE_W/8)-1:0] ld_offset,
    input  logic [1:0]                 ld_size,
    input  logic                       ld_signed,
    output logic                       ld_rsp_valid,
    input  logic                       ld_rsp_ready,
    output logic [63:0]                ld_rsp_data,
    output logic                       ld_rsp_err,
    output logic                       sram_csb,
    output logic                       sram_web,
    output logic [LINE_W/8-1:0]        sram_wmask,
    output logic [INDEX_W-1:0]         sram_addr,
    output logic [LINE_W-1:0]          sram_din,
    input  logic [LINE_W-1:0]          sram_dout
);
    localparam int LANES = LINE_W / 8;
    localparam int OFF_W = $clog2(LANES);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RSP} state_t;
    state_t state_q, state_d;

    logic [OFF_W-1:0] ld_off_q;
    logic [1:0]       ld_size_q;
    logic             ld_signed_q;
    logic             ld_err_q;
    logic [63:0]      rsp_data_q;
    logic             rsp_err_q;

    logic [OFF_W-1:0] st_amask, ld_amask;
    logic             st_aligned, ld_aligned;
    logic [LANES-1:0] st_wmask;
    logic [LINE_W-1:0] st_din;
    logic [2:0]       lane;
    logic [63:0]      rd_bytes;
    logic [63:0]      ld_ext;
    logic             ld_fire;

    assign st_amask   = OFF_W'((32'd1 << st_size) - 32'd1);
    assign ld_amask   = OFF_W'((32'd1 << ld_size) - 32'd1);
    assign st_aligned = (st_offset & st_amask) == '0;
    assign ld_aligned = (ld_offset & ld_amask) == '0;
    assign st_wmask   = LANES'((32'd1 << (32'd1 << st_size)) - 32'd1) << st_offset;

    // Rotate the store data so that lane st_offset carries st_data[7:0].
    always_comb begin
        st_din = '0;
        lane   = '0;
        for (int i = 0; i < LANES; i++) begin
            lane = 3'(i - int'(st_offset));
            st_din[8*i +: 8] = st_data[8*lane +: 8];
        end
    end

    assign rd_bytes = 64'(sram_dout >> {ld_off_q, 3'b000});

    always_comb begin
        ld_ext = rd_bytes;
        case (ld_size_q)
            2'd0:    ld_ext = {{56{ld_signed_q & rd_bytes[7]}},  rd_bytes[7:0]};
            2'd1:    ld_ext = {{48{ld_signed_q & rd_bytes[15]}}, rd_bytes[15:0]};
            2'd2:    ld_ext = {{32{ld_signed_q & rd_bytes[31]}}, rd_bytes[31:0]};
            default: ld_ext = rd_bytes;
        endcase
    end

    always_comb begin
        fill_ready = 1'b0;
        st_ready   = 1'b0;
        ld_ready   = 1'b0;
        ld_fire    = 1'b0;
        sram_csb   = 1'b1;
        sram_web   = 1'b1;
        sram_wmask = '0;
        sram_addr  = '0;
        sram_din   = '0;
        state_d    = state_q;
        if (!rst) begin
            fill_ready = 1'b1;
            st_ready   = !fill_valid;
            ld_ready   = (state_q == IDLE) && !fill_valid && !st_valid;
            ld_fire    = ld_ready && ld_valid;
            if (fill_valid) begin
                sram_csb   = 1'b0;
                sram_web   = 1'b0;
                sram_wmask = '1;
                sram_addr  = fill_index;
                sram_din   = fill_data;
            end else if (st_valid) begin
                // a misaligned store is consumed but never reaches the array
                if (st_aligned) begin
                    sram_csb   = 1'b0;
                    sram_web   = 1'b0;
                    sram_wmask = st_wmask;
                    sram_addr  = st_index;
                    sram_din   = st_din;
                end
            end else if (ld_fire && ld_aligned) begin
                sram_csb  = 1'b0;
                sram_addr = ld_index;
            end
            case (state_q)
                IDLE:    if (ld_fire) state_d = RD_WAIT;
                RD_WAIT: state_d = RSP;
                RSP:     if (ld_rsp_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ld_off_q    <= '0;
            ld_size_q   <= '0;
            ld_signed_q <= 1'b0;
            ld_err_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (ld_fire) begin
                ld_off_q    <= ld_offset;
                ld_size_q   <= ld_size;
                ld_signed_q <= ld_signed;
                ld_err_q    <= !ld_aligned;
            end
            if (state_q == RD_WAIT) begin
                rsp_data_q <= ld_err_q ? 64'd0 : ld_ext;
                rsp_err_q  <= ld_err_q;
            end
        end
    end

    assign ld_rsp_valid = (state_q == RSP);
    assign ld_rsp_data  = rsp_data_q;
    assign ld_rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_dcache_data_ctrl.sv
// Bench for dcache_data_ctrl: byte-array cache model plus per-cycle output checker,
// an SRAM behavioural model, and directed scenarios with literal expectations.
module tb_dcache_data_ctrl;
    logic         clk = 1'b0;
    logic         rst;
    logic         fill_valid, fill_ready;
    logic [5:0]   fill_index;
    logic [127:0] fill_data;
    logic         st_valid, st_ready;
    logic [5:0]   st_index;
    logic [3:0]   st_offset;
    logic [1:0]   st_size;
    logic [63:0]  st_data;
    logic         ld_valid, ld_ready;
    logic [5:0]   ld_index;
    logic [3:0]   ld_offset;
    logic [1:0]   ld_size;
    logic         ld_signed;
    logic         ld_rsp_valid, ld_rsp_ready;
    logic [63:0]  ld_rsp_data;
    logic         ld_rsp_err;
    logic         sram_csb, sram_web;
    logic [15:0]  sram_wmask;
    logic [5:0]   sram_addr;
    logic [127:0] sram_din;
    logic [127:0] sram_dout;

    int checks = 0;
    int errors = 0;

    dcache_data_ctrl dut (
        .clk(clk), .rst(rst),
        .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_index(fill_index), .fill_data(fill_data),
        .st_valid(st_valid), .st_ready(st_ready), .st_index(st_index), .st_offset(st_offset),
        .st_size(st_size), .st_data(st_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_index(ld_index), .ld_offset(ld_offset),
        .ld_size(ld_size), .ld_signed(ld_signed),
        .ld_rsp_valid(ld_rsp_valid), .ld_rsp_ready(ld_rsp_ready), .ld_rsp_data(ld_rsp_data),
        .ld_rsp_err(ld_rsp_err),
        .sram_csb(sram_csb), .sram_web(sram_web), .sram_wmask(sram_wmask), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_dout(sram_dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // SRAM: pins captured mid-cycle, applied at the rising edge, read data appears after the falling edge
    logic [127:0] sram_mem [0:63];
    logic         s_csb, s_web;
    logic [15:0]  s_wmask;
    logic [5:0]   s_addr;
    logic [127:0] s_din, rd_q;
    initial begin
        for (int i = 0; i < 64; i++) sram_mem[i] = '0;
        sram_dout = '0;
        rd_q = '0;
        s_csb = 1'b1;
        s_web = 1'b1;
        s_wmask = '0;
        s_addr = '0;
        s_din = '0;
    end
    always @(negedge clk) begin
        sram_dout = rd_q;
        s_csb = sram_csb; s_web = sram_web; s_wmask = sram_wmask; s_addr = sram_addr; s_din = sram_din;
    end
    always @(posedge clk) begin
        if (!s_csb) begin
            if (!s_web) begin
                for (int b = 0; b < 16; b++)
                    if (s_wmask[b]) sram_mem[s_addr][8*b +: 8] = s_din[8*b +: 8];
            end else begin
                rd_q = sram_mem[s_addr];
            end
        end
    end

    // Reference model: cache contents as bytes, one outstanding load with its age and predicted result
    logic [7:0]  mem_m [0:63][0:15];
    bit          pend = 0;
    int          age = 0;
    logic [63:0] exp_d = '0;
    logic        exp_e = 1'b0;
    bit          p_rst = 1, p_fill = 0, p_st = 0, p_ld = 0, p_rsp = 0;
    bit          e_ld_rdy, e_rsp_v;
    logic [15:0]  e_mask;
    logic [127:0] e_din, din_mask;
    int          n;
    initial for (int i = 0; i < 64; i++) for (int b = 0; b < 16; b++) mem_m[i][b] = 8'h00;

    always @(posedge clk) begin
        if (p_rst) begin
            pend = 0;
        end else begin
            if (p_fill)
                for (int b = 0; b < 16; b++) mem_m[fill_index][b] = fill_data[8*b +: 8];
            if (p_st) begin
                n = 1 << st_size;
                if ((st_offset % n) == 0)
                    for (int b = 0; b < n; b++) mem_m[st_index][int'(st_offset) + b] = st_data[8*b +: 8];
            end
            if (pend) begin
                age++;
                if (p_rsp) pend = 0;
            end
            if (p_ld) begin
                pend = 1;
                age = 0;
                n = 1 << ld_size;
                exp_d = '0;
                exp_e = (ld_offset % n) != 0;
                if (!exp_e) begin
                    for (int b = 0; b < n; b++) exp_d[8*b +: 8] = mem_m[ld_index][int'(ld_offset) + b];
                    if (ld_signed && n < 8 && mem_m[ld_index][int'(ld_offset) + n - 1][7])
                        for (int b = n; b < 8; b++) exp_d[8*b +: 8] = 8'hFF;
                end
            end
        end
        #3;
        if (rst) begin
            e_ld_rdy = 0;
            e_rsp_v  = 0;
            chk("rst_fill_ready", fill_ready, 0);
            chk("rst_st_ready", st_ready, 0);
            chk("rst_ld_ready", ld_ready, 0);
            chk("rst_rsp_valid", ld_rsp_valid, 0);
            chk("rst_rsp_data", ld_rsp_data, 0);
            chk("rst_rsp_err", ld_rsp_err, 0);
            chk("rst_sram", {sram_csb, sram_web, sram_wmask, sram_addr}, {2'b11, 16'h0, 6'h0});
            chk("rst_din", sram_din, 0);
        end else begin
            e_ld_rdy = !fill_valid && !st_valid && !pend;
            e_rsp_v  = pend && age >= 1;
            chk("fill_ready", fill_ready, 1);
            chk("st_ready", st_ready, !fill_valid);
            chk("ld_ready", ld_ready, e_ld_rdy);
            chk("rsp_valid", ld_rsp_valid, e_rsp_v);
            if (e_rsp_v) begin
                chk("rsp_data", ld_rsp_data, exp_d);
                chk("rsp_err", ld_rsp_err, exp_e);
            end
            if (fill_valid) begin
                chk("fill_pins", {sram_csb, sram_web, sram_wmask, sram_addr}, {2'b00, 16'hFFFF, fill_index});
                chk("fill_din", sram_din, fill_data);
            end else if (st_valid && (st_offset % (1 << st_size)) == 0) begin
                n = 1 << st_size;
                e_mask = '0;
                e_din = '0;
                din_mask = '0;
                for (int b = 0; b < n; b++) begin
                    e_mask[int'(st_offset) + b] = 1'b1;
                    e_din[8*(int'(st_offset) + b) +: 8] = st_data[8*b +: 8];
                    din_mask[8*(int'(st_offset) + b) +: 8] = 8'hFF;
                end
                chk("st_pins", {sram_csb, sram_web, sram_wmask, sram_addr}, {2'b00, e_mask, st_index});
                chk("st_din", sram_din & din_mask, e_din);
            end else if (!st_valid && ld_valid && e_ld_rdy && (ld_offset % (1 << ld_size)) == 0) begin
                chk("ld_pins", {sram_csb, sram_web, sram_wmask, sram_addr}, {2'b01, 16'h0, ld_index});
            end else begin
                chk("idle_pins", {sram_csb, sram_web, sram_wmask, sram_addr}, {2'b11, 16'h0, 6'h0});
                chk("idle_din", sram_din, 0);
            end
        end
        p_rst  = rst;
        p_fill = !rst && fill_valid;
        p_st   = !rst && st_valid && !fill_valid;
        p_ld   = !rst && ld_valid && e_ld_rdy;
        p_rsp  = !rst && e_rsp_v && ld_rsp_ready;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_ld(input logic [5:0] idx, input logic [3:0] off, input logic [1:0] sz, input logic sgn);
        bit fired;
        fired = 0;
        ld_index = idx; ld_offset = off; ld_size = sz; ld_signed = sgn; ld_valid = 1'b1;
        for (int i = 0; i < 10 && !fired; i++) begin
            #1;
            fired = ld_ready;
            cyc();
        end
        ld_valid = 1'b0;
        if (!fired) chk("ld_issue_timeout", 0, 1);
    endtask

    task automatic expect_rsp(input string nm, input logic [63:0] d, input logic e);
        int i;
        #1;
        chk({nm, "_early"}, ld_rsp_valid, 0);
        cyc();
        st_valid = 1'b0;
        fill_valid = 1'b0;
        #1;
        for (i = 0; i < 8 && !ld_rsp_valid; i++) cyc();
        chk({nm, "_valid"}, ld_rsp_valid, 1);
        chk({nm, "_latency"}, i, 0);
        chk({nm, "_data"}, ld_rsp_data, d);
        chk({nm, "_err"}, ld_rsp_err, e);
        ld_rsp_ready = 1'b1;
        cyc();
        ld_rsp_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        fill_valid = 0; fill_index = 0; fill_data = 0;
        st_valid = 0; st_index = 0; st_offset = 0; st_size = 0; st_data = 0;
        ld_valid = 0; ld_index = 0; ld_offset = 0; ld_size = 0; ld_signed = 0;
        ld_rsp_ready = 0;
        repeat (3) cyc();
        fill_valid = 1'b1;
        #1;
        chk("lit_rst_fill_ready", fill_ready, 0);
        chk("lit_rst_csb", sram_csb, 1);

        // first edge after reset release accepts a fill
        cyc();
        rst = 1'b0;
        fill_index = 6'd5;
        fill_data = 128'h0F0E0D0C0B0A09080706050403020100;
        #1;
        chk("lit_fill_ready", fill_ready, 1);
        chk("lit_fill_wmask", sram_wmask, 16'hFFFF);
        cyc();
        fill_valid = 1'b0;

        issue_ld(6'd5, 4'd4, 2'd2, 1'b0);
        expect_rsp("lit_ld_w_off4", 64'h0000_0000_0706_0504, 1'b0);

        st_valid = 1'b1; st_index = 6'd5; st_offset = 4'd3; st_size = 2'd0; st_data = 64'hFF;
        #1;
        chk("lit_st_wmask", sram_wmask, 16'h0008);
        cyc();
        st_valid = 1'b0;
        issue_ld(6'd5, 4'd0, 2'd2, 1'b1);
        expect_rsp("lit_ld_w_signed", 64'hFFFF_FFFF_FF02_0100, 1'b0);

        // fill > store > load when all three arrive together
        fill_valid = 1'b1; fill_index = 6'd9; fill_data = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        st_valid = 1'b1; st_index = 6'd9; st_offset = 4'd8; st_size = 2'd3; st_data = 64'h1122_3344_5566_7788;
        ld_valid = 1'b1; ld_index = 6'd9; ld_offset = 4'd8; ld_size = 2'd3; ld_signed = 1'b0;
        #1;
        chk("lit_pri1_st_ready", st_ready, 0);
        chk("lit_pri1_ld_ready", ld_ready, 0);
        cyc();
        fill_valid = 1'b0;
        #1;
        chk("lit_pri2_st_ready", st_ready, 1);
        chk("lit_pri2_ld_ready", ld_ready, 0);
        cyc();
        st_valid = 1'b0;
        #1;
        chk("lit_pri3_ld_ready", ld_ready, 1);
        cyc();
        ld_valid = 1'b0;
        expect_rsp("lit_ld_d_off8", 64'h1122_3344_5566_7788, 1'b0);

        // misaligned load: error response, array untouched
        ld_valid = 1'b1; ld_index = 6'd5; ld_offset = 4'd2; ld_size = 2'd2; ld_signed = 1'b0;
        #1;
        chk("lit_misal_csb", sram_csb, 1);
        cyc();
        ld_valid = 1'b0;
        expect_rsp("lit_ld_misal", 64'd0, 1'b1);

        // misaligned store is consumed and dropped
        st_valid = 1'b1; st_index = 6'd5; st_offset = 4'd1; st_size = 2'd1; st_data = 64'hAAAA;
        #1;
        chk("lit_st_misal_csb", sram_csb, 1);
        cyc();
        st_valid = 1'b0;

        // response back-pressure with a concurrent store
        issue_ld(6'd5, 4'd0, 2'd3, 1'b1);
        cyc();
        ld_valid = 1'b1; ld_index = 6'd5; ld_offset = 4'd0; ld_size = 2'd0;
        st_valid = 1'b1; st_index = 6'd7; st_offset = 4'd0; st_size = 2'd1; st_data = 64'hBEEF;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("lit_hold_valid", ld_rsp_valid, 1);
            chk("lit_hold_data", ld_rsp_data, 64'h0706_0504_FF02_0100);
            chk("lit_hold_ld_ready", ld_ready, 0);
            if (i == 0) chk("lit_hold_st_ready", st_ready, 1);
            cyc();
            st_valid = 1'b0;
        end
        ld_valid = 1'b0;
        ld_rsp_ready = 1'b1;
        cyc();
        ld_rsp_ready = 1'b0;
        issue_ld(6'd7, 4'd0, 2'd1, 1'b1);
        expect_rsp("lit_ld_h_idx7", 64'hFFFF_FFFF_FFFF_BEEF, 1'b0);

        // store to the same line while the load is in RD_WAIT must not leak into its data
        issue_ld(6'd5, 4'd0, 2'd0, 1'b0);
        st_valid = 1'b1; st_index = 6'd5; st_offset = 4'd0; st_size = 2'd0; st_data = 64'h9C;
        expect_rsp("lit_ld_before_st", 64'h0, 1'b0);
        issue_ld(6'd5, 4'd0, 2'd0, 1'b1);
        expect_rsp("lit_ld_after_st", 64'hFFFF_FFFF_FFFF_FF9C, 1'b0);

        // reset pulse while a load waits on the array
        issue_ld(6'd5, 4'd0, 2'd0, 1'b0);
        rst = 1'b1;
        #1;
        chk("lit_rstpulse_csb", sram_csb, 1);
        chk("lit_rstpulse_valid", ld_rsp_valid, 0);
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("lit_rstpulse_no_rsp", ld_rsp_valid, 0);
            cyc();
        end
        issue_ld(6'd9, 4'd0, 2'd3, 1'b0);
        expect_rsp("lit_ld_after_rst", 64'hFEDC_BA98_7654_3210, 1'b0);

        repeat (2) cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
